// File: rtl/evt_cap_pkg.sv
// Shared defaults and helpers for the event-capture path.
package evt_cap_pkg;

  localparam int DEF_W             = 32;
  localparam int DEF_N             = 5;
  localparam int DEF_DEPTH_BITS    = 5;
  localparam int DEF_DROP_CNT_BITS = 16;

  // Number of set bits in a (zero-extended) vector of up to 32 bits.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/evt_lane_compactor.sv
// Packs the valid event lanes into contiguous low lanes, ascending lane order.
module evt_lane_compactor #(
  parameter int W        = 32,
  parameter int N        = 5,
  parameter int CNT_BITS = 3
) (
  input  logic [W*N-1:0]      data_in,
  input  logic [N-1:0]        valid,
  output logic [W*N-1:0]      data_out,
  output logic [CNT_BITS-1:0] cnt
);

  int idx;

  // Route the j-th valid lane to output lane idx; unused output lanes stay zero.
  always_comb begin
    data_out = '0;
    idx      = 0;
    for (int j = 0; j < N; j++) begin
      if (valid[j]) begin
        for (int k = 0; k < N; k++) begin
          if (k == idx) data_out[k*W +: W] = data_in[j*W +: W];
        end
        idx = idx + 1;
      end
    end
    cnt = CNT_BITS'(idx);
  end

endmodule

// File: rtl/evt_word_packer.sv
// Compacts per-cycle event lanes into one contiguous RAM write, tracks fill level,
// read pointer and dropped batches.
module evt_word_packer
  import evt_cap_pkg::*;
#(
  parameter int INPUT_WORD_SIZE = DEF_W,
  parameter int NUM_INPUTS      = DEF_N,
  parameter int DEPTH_BITS      = DEF_DEPTH_BITS,
  parameter int DROP_CNT_BITS   = DEF_DROP_CNT_BITS
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [INPUT_WORD_SIZE*NUM_INPUTS-1:0] ev_data,
  input  logic [NUM_INPUTS-1:0]                ev_valid,
  input  logic                                 rd_pop,
  output logic [INPUT_WORD_SIZE*NUM_INPUTS-1:0] ram_d,
  output logic [NUM_INPUTS-1:0]                ram_wr_en,
  output logic [DEPTH_BITS-1:0]                ram_wr_addr,
  output logic [DEPTH_BITS-1:0]                ram_rd_addr,
  output logic                                 rd_valid,
  output logic [DEPTH_BITS:0]                  words_avail,
  output logic                                 ovfl,
  output logic [DROP_CNT_BITS-1:0]             drop_count
);

  localparam int W        = INPUT_WORD_SIZE;
  localparam int N        = NUM_INPUTS;
  localparam int DEPTH    = 2 ** DEPTH_BITS;
  localparam int CW       = DEPTH_BITS + 1;
  localparam int CNT_BITS = $clog2(N + 1);

  logic [W*N-1:0]        cmp_data;
  logic [CNT_BITS-1:0]   cmp_cnt;
  logic [W*N-1:0]        s1_data;
  logic [CNT_BITS-1:0]   s1_cnt;
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [CW-1:0]         pend;
  logic [CW-1:0]         free;
  logic [CW-1:0]         s1_cnt_w;
  logic                  accept;
  logic                  drop;
  logic                  pop_ok;
  logic [N-1:0]          wr_mask;

  evt_lane_compactor #(
    .W        (W),
    .N        (N),
    .CNT_BITS (CNT_BITS)
  ) u_compactor (
    .data_in  (ev_data),
    .valid    (ev_valid),
    .data_out (cmp_data),
    .cnt      (cmp_cnt)
  );

  // Words issued this cycle are still uncommitted, so they reduce free space;
  // a pop on the same edge is deliberately not credited.
  assign pend     = CW'(popcount(32'(ram_wr_en)));
  assign free     = CW'(DEPTH) - words_avail - pend;
  assign s1_cnt_w = CW'(s1_cnt);
  assign accept   = (s1_cnt != '0) && (s1_cnt_w <= free);
  assign drop     = s1_cnt_w > free;
  assign rd_valid = words_avail >= CW'(2);
  assign pop_ok   = rd_pop & rd_valid;

  // Thermometer write-enable covering the low s1_cnt lanes.
  always_comb begin
    wr_mask = '0;
    for (int k = 0; k < N; k++) begin
      if (CNT_BITS'(k) < s1_cnt) wr_mask[k] = 1'b1;
    end
  end

  // Stage 1: register the compacted lanes and their count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data <= '0;
      s1_cnt  <= '0;
    end else begin
      s1_data <= cmp_data;
      s1_cnt  <= cmp_cnt;
    end
  end

  // Stage 2: issue the whole batch to the RAM, or drop it whole when it does not fit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_d       <= '0;
      ram_wr_en   <= '0;
      ram_wr_addr <= '0;
      wr_ptr      <= '0;
      ovfl        <= 1'b0;
      drop_count  <= '0;
    end else begin
      ram_d     <= '0;
      ram_wr_en <= '0;
      ovfl      <= drop;
      if (accept) begin
        ram_d       <= s1_data;
        ram_wr_en   <= wr_mask;
        ram_wr_addr <= wr_ptr;
        wr_ptr      <= wr_ptr + DEPTH_BITS'(s1_cnt);
      end
      if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
    end
  end

  // Fill level and read pointer: credit committed words, debit honoured pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_avail <= '0;
      ram_rd_addr <= '0;
    end else begin
      words_avail <= words_avail + pend - (pop_ok ? CW'(2) : CW'(0));
      if (pop_ok) ram_rd_addr <= ram_rd_addr + DEPTH_BITS'(2);
    end
  end

endmodule

// File: tb/tb_evt_word_packer.sv
// Directed bench for evt_word_packer (W=32, N=5, DEPTH_BITS=5).
module tb_evt_word_packer;

  logic         clk;
  logic         rst_n;
  logic [159:0] ev_data;
  logic [4:0]   ev_valid;
  logic         rd_pop;
  logic [159:0] ram_d;
  logic [4:0]   ram_wr_en;
  logic [4:0]   ram_wr_addr;
  logic [4:0]   ram_rd_addr;
  logic         rd_valid;
  logic [5:0]   words_avail;
  logic         ovfl;
  logic [15:0]  drop_count;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] LA = 32'hAAAA_0001;
  localparam logic [31:0] LB = 32'hBBBB_0002;
  localparam logic [31:0] LC = 32'hCCCC_0003;
  localparam logic [31:0] LD = 32'hDDDD_0004;
  localparam logic [31:0] LE = 32'hEEEE_0005;

  evt_word_packer #(
    .INPUT_WORD_SIZE (32),
    .NUM_INPUTS      (5),
    .DEPTH_BITS      (5),
    .DROP_CNT_BITS   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ev_data     (ev_data),
    .ev_valid    (ev_valid),
    .rd_pop      (rd_pop),
    .ram_d       (ram_d),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_rd_addr (ram_rd_addr),
    .rd_valid    (rd_valid),
    .words_avail (words_avail),
    .ovfl        (ovfl),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a batch for exactly one sampling edge.
  task automatic feed(input logic [4:0] v);
    ev_valid = v;
    tick(1);
    ev_valid = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ram_d"}, ram_d, '0);
    chk({tag, " wr_en"}, 160'(ram_wr_en), '0);
    chk({tag, " wr_addr"}, 160'(ram_wr_addr), '0);
    chk({tag, " rd_addr"}, 160'(ram_rd_addr), '0);
    chk({tag, " rd_valid"}, 160'(rd_valid), '0);
    chk({tag, " words"}, 160'(words_avail), '0);
    chk({tag, " ovfl"}, 160'(ovfl), '0);
    chk({tag, " drops"}, 160'(drop_count), '0);
  endtask

  initial begin
    int waited;
    rst_n    = 1'b0;
    rd_pop   = 1'b0;
    ev_data  = {LE, LD, LC, LB, LA};
    ev_valid = '0;

    // Reset held with random valid traffic.
    for (int i = 0; i < 4; i++) begin
      ev_valid = 5'($urandom);
      tick(1);
    end
    chk_all_zero("rst_hold");
    ev_valid = '0;
    rst_n    = 1'b1;
    tick(1);

    // Mid-burst reset: outputs clear without a clock edge, nothing written after release.
    ev_valid = 5'h1f;
    tick(2);
    chk("burst wr_en", 160'(ram_wr_en), 160'(5'h1f));
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    ev_valid = '0;
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("post_rst wr_en", 160'(ram_wr_en), '0);
      chk("post_rst words", 160'(words_avail), '0);
    end

    // Compaction: lanes 1,2,4 -> B,C,E at lanes 0..2.
    feed(5'b10110);
    tick(1);
    chk("cmp ram_d", ram_d, {32'h0, 32'h0, LE, LC, LB});
    chk("cmp wr_en", 160'(ram_wr_en), 160'(5'b00111));
    chk("cmp wr_addr", 160'(ram_wr_addr), 160'(0));
    chk("cmp words_before", 160'(words_avail), 160'(0));
    tick(1);
    chk("cmp words", 160'(words_avail), 160'(3));
    chk("cmp rd_valid", 160'(rd_valid), 160'(1));
    chk("cmp wr_en_clr", 160'(ram_wr_en), '0);

    // Move both pointers to 30 with an empty buffer.
    for (int i = 0; i < 5; i++) feed(5'h1f);
    feed(5'b00011);
    tick(2);
    chk("fill30 words", 160'(words_avail), 160'(30));
    rd_pop = 1'b1;
    tick(15);
    rd_pop = 1'b0;
    chk("drain words", 160'(words_avail), 160'(0));
    chk("drain rd_addr", 160'(ram_rd_addr), 160'(30));
    chk("drain rd_valid", 160'(rd_valid), 160'(0));

    // Wrapping write of 5 words at address 30.
    feed(5'h1f);
    tick(1);
    chk("wrap wr_addr", 160'(ram_wr_addr), 160'(30));
    chk("wrap wr_en", 160'(ram_wr_en), 160'(5'h1f));
    chk("wrap ram_d", ram_d, {LE, LD, LC, LB, LA});
    tick(1);
    chk("wrap words", 160'(words_avail), 160'(5));
    rd_pop = 1'b1;
    tick(1);
    chk("pop1 words", 160'(words_avail), 160'(3));
    chk("pop1 rd_addr", 160'(ram_rd_addr), 160'(0));
    tick(1);
    chk("pop2 words", 160'(words_avail), 160'(1));
    chk("pop2 rd_addr", 160'(ram_rd_addr), 160'(2));
    tick(1);
    chk("pop3 ignored words", 160'(words_avail), 160'(1));
    chk("pop3 ignored rd_addr", 160'(ram_rd_addr), 160'(2));
    chk("lone word rd_valid", 160'(rd_valid), 160'(0));
    rd_pop = 1'b0;

    // wr_ptr wrapped to 3; fill up to 28 words.
    feed(5'h1f);
    tick(1);
    chk("wrapped wr_ptr", 160'(ram_wr_addr), 160'(3));
    for (int i = 0; i < 4; i++) feed(5'h1f);
    feed(5'b00011);
    tick(2);
    chk("fill28 words", 160'(words_avail), 160'(28));

    // 5 words with 4 free: whole batch dropped.
    feed(5'h1f);
    tick(1);
    chk("ovf wr_en", 160'(ram_wr_en), '0);
    chk("ovf pulse", 160'(ovfl), 160'(1));
    chk("ovf drops", 160'(drop_count), 160'(1));
    tick(1);
    chk("ovf pulse_end", 160'(ovfl), 160'(0));
    chk("ovf words", 160'(words_avail), 160'(28));

    // 4 words exactly fit.
    feed(5'b01111);
    tick(1);
    chk("fit wr_en", 160'(ram_wr_en), 160'(5'b01111));
    chk("fit wr_addr", 160'(ram_wr_addr), 160'(30));
    chk("fit ovfl", 160'(ovfl), 160'(0));
    tick(1);
    chk("full words", 160'(words_avail), 160'(32));
    chk("full rd_valid", 160'(rd_valid), 160'(1));

    // Drain to 4, then pop while a 3-word write commits.
    rd_pop = 1'b1;
    tick(14);
    rd_pop = 1'b0;
    chk("drain4 words", 160'(words_avail), 160'(4));
    chk("drain4 rd_addr", 160'(ram_rd_addr), 160'(30));
    feed(5'b00111);
    tick(1);
    chk("same wr_en", 160'(ram_wr_en), 160'(5'b00111));
    chk("same wr_addr", 160'(ram_wr_addr), 160'(2));
    rd_pop = 1'b1;
    tick(1);
    rd_pop = 1'b0;
    chk("same words", 160'(words_avail), 160'(5));
    chk("same rd_addr", 160'(ram_rd_addr), 160'(0));

    // Saturate the drop counter with continuous full batches.
    ev_valid = 5'h1f;
    waited   = 0;
    while (drop_count != 16'hFFFF && waited < 70000) begin
      tick(1);
      waited++;
    end
    chk("sat reached", 160'(drop_count), 160'(16'hFFFF));
    tick(5);
    chk("sat hold", 160'(drop_count), 160'(16'hFFFF));
    chk("sat ovfl_cont", 160'(ovfl), 160'(1));
    chk("sat words", 160'(words_avail), 160'(30));
    ev_valid = '0;
    tick(3);
    chk("sat idle ovfl", 160'(ovfl), 160'(0));
    feed(5'h1f);
    tick(1);
    chk("sat pulse", 160'(ovfl), 160'(1));
    chk("sat count", 160'(drop_count), 160'(16'hFFFF));
    tick(1);
    chk("sat pulse_end", 160'(ovfl), 160'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
